// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between the instruction-fetch and
// data-access requesters, with a bounded-starvation guarantee for fetches.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ok,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ok,
  output logic              stallreq_for_mem,
  output logic              mem_req,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_data;
  logic             resp_now;

  // Data wins a tie until the fetch side has been passed over STARVE_MAX times.
  assign grant_data = data_req & (~inst_req | (starve_cnt != CNT_MAX));

  // Memory has returned the word (or write completion) for the accepted access.
  assign resp_now = ((state == ISSUE) && mem_addr_ok && mem_data_ok) ||
                    ((state == WAIT) && mem_data_ok);

  assign stallreq_for_mem = (inst_req & ~inst_ok) | (data_req & ~data_ok);

  // NOTE: every register here, including the rdata holding registers, is plain
  // flop state and gets an explicit reset value; all updates use <= so the
  // whole block sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_wen    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_ok    <= 1'b0;
      data_ok    <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;

      if (resp_now) begin
        if (owner == OWN_INST) begin
          inst_rdata <= mem_rdata;
          inst_ok    <= 1'b1;
        end else if (owner == OWN_DATA) begin
          // Stores complete without touching the load result register.
          if (mem_wen == 4'b0000) data_rdata <= mem_rdata;
          data_ok <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (grant_data) begin
            owner     <= OWN_DATA;
            mem_addr  <= data_addr;
            mem_wen   <= data_wen;
            mem_wdata <= data_wdata;
            mem_req   <= 1'b1;
            state     <= ISSUE;
            if (inst_req && (starve_cnt != CNT_MAX)) starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (inst_req) begin
            owner      <= OWN_INST;
            mem_addr   <= inst_addr;
            mem_wen    <= 4'b0000;
            mem_wdata  <= '0;
            mem_req    <= 1'b1;
            state      <= ISSUE;
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= mem_data_ok ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (mem_data_ok) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory checks issued
// requests, a monitor checks every ok pulse against queued expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wen;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_ok, data_ok, stallreq_for_mem;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  // Memory inputs come from the model or from directed code, never both.
  logic        model_en, model_addr_ok, model_data_ok;
  logic [31:0] model_rdata;
  logic        man_addr_ok, man_data_ok;
  logic [31:0] man_rdata;
  int          addr_delay;
  bit          coincide;

  assign mem_addr_ok = model_en ? model_addr_ok : man_addr_ok;
  assign mem_data_ok = model_en ? model_data_ok : man_data_ok;
  assign mem_rdata   = model_en ? model_rdata   : man_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ok(data_ok), .stallreq_for_mem(stallreq_for_mem),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { bit is_data; bit is_write; logic [31:0] rdata; } sb_t;
  typedef struct { logic [31:0] addr; logic [3:0] wen; logic [31:0] wdata; } mreq_t;

  sb_t   sb_q[$];
  mreq_t mem_q[$];
  logic [31:0] exp_inst_rd = '0;
  logic [31:0] exp_data_rd = '0;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h3C08_BFAF : ~a;
  endfunction

  task automatic push_exp(input bit is_data, input logic [31:0] a, input logic [3:0] wen,
                          input logic [31:0] wd);
    sb_t   s;
    mreq_t m;
    s.is_data = is_data; s.is_write = (wen != 4'b0000); s.rdata = rd_of(a);
    m.addr = a; m.wen = is_data ? wen : 4'b0000; m.wdata = is_data ? wd : 32'h0;
    sb_q.push_back(s);
    mem_q.push_back(m);
  endtask

  // Behavioural memory: optional addr_ok backpressure, data same cycle or next.
  bit          pend;
  logic [31:0] pend_data;
  int          stall_cnt;
  always @(negedge clk) begin
    mreq_t m;
    logic [31:0] rd;
    model_addr_ok = 1'b0;
    model_data_ok = 1'b0;
    if (!rst || !model_en) begin
      pend = 0; stall_cnt = 0;
    end else if (pend) begin
      model_data_ok = 1'b1; model_rdata = pend_data; pend = 0;
    end else if (mem_req) begin
      if (stall_cnt < addr_delay) stall_cnt++;
      else begin
        stall_cnt = 0;
        model_addr_ok = 1'b1;
        if (mem_q.size() == 0) check("mem_unexpected_req", 1, 0);
        else begin
          m = mem_q.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_wen", mem_wen, m.wen);
          check("mem_wdata", mem_wdata, m.wdata);
        end
        rd = (mem_wen != 4'b0000) ? 32'hDEAD_BEEF : rd_of(mem_addr);
        if (coincide) begin model_data_ok = 1'b1; model_rdata = rd; end
        else begin pend = 1; pend_data = rd; end
      end
    end
  end

  // Output monitor: pops one expectation per ok pulse.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      if (inst_ok && data_ok) check("both_ok", 1, 0);
      if (inst_ok || data_ok) begin
        if (sb_q.size() == 0) check("unexpected_ok", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("grant_owner", data_ok, e.is_data);
          if (e.is_data) begin
            if (e.is_write) check("store_keeps_rdata", data_rdata, exp_data_rd);
            else begin
              check("data_rdata", data_rdata, e.rdata);
              exp_data_rd = e.rdata;
            end
            check("inst_rdata_hold", inst_rdata, exp_inst_rd);
          end else begin
            check("inst_rdata", inst_rdata, e.rdata);
            exp_inst_rd = e.rdata;
            check("data_rdata_hold", data_rdata, exp_data_rd);
          end
        end
      end
    end
  end

  // One isolated transaction: latency and stall request are checked here.
  task automatic run_one(input string tag, input bit is_data, input logic [31:0] a,
                         input logic [3:0] wen, input logic [31:0] wd, input int exp_lat);
    int lat = 0;
    int stall_bad = 0;
    push_exp(is_data, a, wen, wd);
    if (is_data) begin data_req = 1; data_addr = a; data_wen = wen; data_wdata = wd; end
    else begin inst_req = 1; inst_addr = a; end
    @(negedge clk);
    while (!(is_data ? data_ok : inst_ok) && lat < 50) begin
      if (!stallreq_for_mem) stall_bad++;
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_before_ok"}, stall_bad, 0);
    check({tag, "_stall_at_ok"}, stallreq_for_mem, 0);
    @(posedge clk); #1;
    inst_req = 0; data_req = 0;
  endtask

  task automatic inst_txns(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      inst_req = 1; inst_addr = base + 32'(4 * i);
      do begin @(negedge clk); k++; end while (!inst_ok && k < 100);
      if (!inst_ok) check("inst_timeout", 0, 1);
      @(posedge clk); #1;
    end
    inst_req = 0;
  endtask

  task automatic data_txns(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      data_req = 1; data_addr = base + 32'(4 * i); data_wen = 4'b0000;
      data_wdata = 32'h5000_0000 + 32'(i);
      do begin @(negedge clk); k++; end while (!data_ok && k < 100);
      if (!data_ok) check("data_timeout", 0, 1);
      @(posedge clk); #1;
    end
    data_req = 0;
  endtask

  initial begin
    sb_t s;
    rst = 0; inst_req = 0; data_req = 0; inst_addr = '0; data_addr = '0;
    data_wen = '0; data_wdata = '0; model_en = 0; addr_delay = 0; coincide = 0;
    man_addr_ok = 0; man_data_ok = 0; man_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_oks", {inst_ok, data_ok}, 0);
    check("rst_rdata", {inst_rdata, data_rdata}, 0);
    @(posedge clk); #1;
    rst = 1; model_en = 1;
    @(posedge clk); #1;

    run_one("fetch", 0, 32'hBFC0_0000, 4'b0000, 32'h0, 3);
    run_one("load", 1, 32'h8000_2000, 4'b0000, 32'h0, 3);
    coincide = 1;
    run_one("store", 1, 32'h8000_1000, 4'b0011, 32'h1234_ABCD, 2);
    coincide = 0;

    // Contention: expected grant order d,d,i,d,d,i then the leftover data.
    addr_delay = 1;
    push_exp(1, 32'h8000_3000, 4'b0000, 32'h5000_0000);
    push_exp(1, 32'h8000_3004, 4'b0000, 32'h5000_0001);
    push_exp(0, 32'hBFC0_0100, 4'b0000, 32'h0);
    push_exp(1, 32'h8000_3008, 4'b0000, 32'h5000_0002);
    push_exp(1, 32'h8000_300C, 4'b0000, 32'h5000_0003);
    push_exp(0, 32'hBFC0_0104, 4'b0000, 32'h0);
    push_exp(1, 32'h8000_3010, 4'b0000, 32'h5000_0004);
    fork
      inst_txns(2, 32'hBFC0_0100);
      data_txns(5, 32'h8000_3000);
    join
    addr_delay = 0;
    repeat (2) @(posedge clk); #1;

    // Backpressure with a stray data_ok in ISSUE; requester drops req mid-way.
    model_en = 0;
    s.is_data = 1; s.is_write = 0; s.rdata = 32'h55AA_1234;
    sb_q.push_back(s);
    data_req = 1; data_addr = 32'h8000_4000; data_wen = 4'b0000; data_wdata = 32'h0;
    @(posedge clk); #1;
    data_req = 0;
    for (int k = 0; k < 5; k++) begin
      man_addr_ok = 0; man_data_ok = (k == 2); man_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check("bp_mem_req", mem_req, 1);
      check("bp_mem_addr", mem_addr, 32'h8000_4000);
      @(posedge clk); #1;
    end
    man_addr_ok = 1; man_data_ok = 0;
    @(posedge clk); #1;
    man_addr_ok = 0;
    @(negedge clk);
    check("bp_wait_mem_req", mem_req, 0);
    check("bp_no_early_ok", data_ok, 0);
    @(posedge clk); #1;
    man_data_ok = 1; man_rdata = 32'h55AA_1234;
    @(posedge clk); #1;
    man_data_ok = 0;
    @(negedge clk);
    check("bp_ok", data_ok, 1);
    @(posedge clk); #1;

    // Asynchronous reset while waiting for data.
    inst_req = 1; inst_addr = 32'hBFC0_0200;
    @(posedge clk); #1;
    man_addr_ok = 1;
    @(posedge clk); #1;
    man_addr_ok = 0;
    #2 rst = 0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_oks", {inst_ok, data_ok}, 0);
    check("arst_rdata", {inst_rdata, data_rdata}, 0);
    check("arst_mem_addr", mem_addr, 0);
    exp_inst_rd = '0; exp_data_rd = '0;
    inst_req = 0;
    @(posedge clk); #1;
    rst = 1;
    man_data_ok = 1; man_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("arst_no_ok", {inst_ok, data_ok, mem_req}, 0);
    end
    @(posedge clk); #1;
    man_data_ok = 0; model_en = 1;
    run_one("fetch_after_rst", 0, 32'hBFC0_0000, 4'b0000, 32'h0, 3);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
